// File: rtl/gate_chk_pkg.sv
// Shared types and sizing helpers for the gate truth-table checker.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE
  } state_t;

  function automatic int n_vec(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Settle counter: counts up from zero, flags the last settle cycle.
module settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tc
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CW'(SETTLE - 1));

endmodule

// File: rtl/gate_truth_checker.sv
// Walks every input vector of a gate under test, samples its output
// and compares the measured truth table against an expected one.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter  int N_IN   = 2,
  parameter  int SETTLE = 2,
  localparam int N_VEC  = n_vec(N_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_VEC-1:0] expect_tt,
  input  logic             gate_f,
  output logic [N_IN-1:0]  gate_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    err_count,
  output logic [N_IN-1:0]  fail_idx,
  output logic [N_VEC-1:0] measured_tt
);

  state_t state, next;

  logic [N_VEC-1:0] exp_q;
  logic [N_IN-1:0]  vec;
  logic             tc;
  logic             accept;
  logic             sample;
  logic             mismatch;
  logic             last;

  assign accept   = (state == IDLE) && start;
  assign sample   = (state == SAMPLE);
  assign mismatch = (gate_f != exp_q[vec]);
  assign last     = (vec == N_IN'(N_VEC - 1));

  // Timer only runs while waiting; it restarts at zero on every WAIT entry.
  settle_timer #(
    .SETTLE(SETTLE)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear((state != WAIT) || tc),
    .tc   (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (start) next = WAIT;
      WAIT:    if (tc) next = SAMPLE;
      SAMPLE:  next = last ? IDLE : WAIT;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q       <= '0;
      vec         <= '0;
      gate_in     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      fail_idx    <= '0;
      measured_tt <= '0;
    end else begin
      done <= 1'b0;
      unique case (1'b1)
        accept: begin
          exp_q       <= expect_tt;
          vec         <= '0;
          gate_in     <= '0;
          busy        <= 1'b1;
          pass        <= 1'b0;
          err_count   <= '0;
          fail_idx    <= '0;
          measured_tt <= '0;
        end
        sample: begin
          measured_tt[vec] <= gate_f;
          if (mismatch) begin
            err_count <= err_count + 1'b1;
            if (err_count == '0) fail_idx <= vec;
          end
          if (last) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_count == '0) && !mismatch;
          end else begin
            vec     <= vec + 1'b1;
            gate_in <= vec + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Self-checking bench: table vectors, hand sequences and random tables
// checked against a truth-table comparison model.
module tb_gate_truth_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] expect_tt = '0;
  logic [3:0] gate_tt = '0;
  logic       gate_f;
  logic [1:0] gate_in;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [1:0] fail_idx;
  logic [3:0] measured_tt;

  logic       start3 = 1'b0;
  logic [7:0] expect3 = '0;
  logic [7:0] gate_tt3 = '0;
  logic       gate_f3;
  logic [2:0] gate_in3;
  logic       busy3, done3, pass3;
  logic [3:0] err3;
  logic [2:0] fidx3;
  logic [7:0] meas3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Gates under test are modelled as truth-table lookups.
  assign gate_f  = gate_tt[gate_in];
  assign gate_f3 = gate_tt3[gate_in3];

  gate_truth_checker #(.N_IN(2), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .expect_tt(expect_tt),
    .gate_f(gate_f), .gate_in(gate_in), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .fail_idx(fail_idx),
    .measured_tt(measured_tt)
  );

  gate_truth_checker #(.N_IN(3), .SETTLE(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .expect_tt(expect3),
    .gate_f(gate_f3), .gate_in(gate_in3), .busy(busy3), .done(done3),
    .pass(pass3), .err_count(err3), .fail_idx(fidx3),
    .measured_tt(meas3)
  );

  typedef struct {
    logic [3:0] g;
    logic [3:0] e;
    logic       p;
    logic [2:0] n;
    logic [1:0] fi;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [3:0] g, input logic [3:0] e,
                                output logic p, output int n,
                                output int fi);
    n  = 0;
    fi = 0;
    for (int i = 0; i < 4; i++) begin
      if (g[i] != e[i]) begin
        if (n == 0) fi = i;
        n++;
      end
    end
    p = (n == 0);
  endfunction

  task automatic run(input logic [3:0] g, input logic [3:0] e,
                     output int edges, output logic [15:0] seq);
    gate_tt   = g;
    expect_tt = e;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    seq   = 16'(gate_in);
    edges = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (gate_in != seq[1:0]) seq = {seq[13:0], gate_in};
      if (done) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic wait_done(output int edges);
    edges = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        edges = k;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         n;
    int         mn, mfi;
    logic       mp;
    logic [15:0] seq;
    logic       saw_done;

    tbl[0] = '{4'b1000, 4'b1000, 1'b1, 3'd0, 2'd0};
    tbl[1] = '{4'b1000, 4'b1110, 1'b0, 3'd2, 2'd1};
    tbl[2] = '{4'b0110, 4'b0110, 1'b1, 3'd0, 2'd0};
    tbl[3] = '{4'b1001, 4'b1001, 1'b1, 3'd0, 2'd0};
    tbl[4] = '{4'b1000, 4'b0000, 1'b0, 3'd1, 2'd3};
    tbl[5] = '{4'b1111, 4'b0000, 1'b0, 3'd4, 2'd0};
    tbl[6] = '{4'b0101, 4'b0110, 1'b0, 3'd2, 2'd0};

    #3;
    chk("reset_outs", 32'({gate_in, busy, done, pass, err_count,
                           fail_idx, measured_tt}), 32'd0);
    chk("reset_outs3", 32'({gate_in3, busy3, done3, pass3, err3,
                            fidx3, meas3}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run(tbl[i].g, tbl[i].e, n, seq);
      chk($sformatf("tbl%0d_latency", i), 32'(n), 32'd12);
      chk($sformatf("tbl%0d_meas", i), 32'(measured_tt), 32'(tbl[i].g));
      chk($sformatf("tbl%0d_pass", i), 32'(pass), 32'(tbl[i].p));
      chk($sformatf("tbl%0d_err", i), 32'(err_count), 32'(tbl[i].n));
      chk($sformatf("tbl%0d_fidx", i), 32'(fail_idx), 32'(tbl[i].fi));
      chk($sformatf("tbl%0d_seq", i), 32'(seq), 32'h1B);
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_pulse", i), 32'(done), 32'd0);
      chk($sformatf("tbl%0d_hold", i), 32'(gate_in), 32'd3);
    end

    // Back-to-back: start held high through the done cycle.
    gate_tt   = 4'b0110;
    expect_tt = 4'b0110;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(n);
    chk("b2b1_latency", 32'(n), 32'd12);
    chk("b2b1_pass", 32'(pass), 32'd1);
    chk("b2b1_meas", 32'(measured_tt), 32'h6);
    gate_tt   = 4'b1001;
    expect_tt = 4'b1001;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b2_busy", 32'(busy), 32'd1);
    chk("b2b2_clear", 32'({pass, measured_tt}), 32'd0);
    chk("b2b2_vec0", 32'(gate_in), 32'd0);
    wait_done(n);
    chk("b2b2_latency", 32'(n), 32'd12);
    chk("b2b2_pass", 32'(pass), 32'd1);
    chk("b2b2_meas", 32'(measured_tt), 32'h9);

    // Restart and table change while busy must be ignored.
    gate_tt   = 4'b1000;
    expect_tt = 4'b1000;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) begin
        start     = 1'b1;
        expect_tt = 4'b0111;
      end
      if (k == 5) start = 1'b0;
      if (done) begin
        n = k;
        break;
      end
    end
    chk("ign_latency", 32'(n), 32'd12);
    chk("ign_pass", 32'(pass), 32'd1);
    chk("ign_err", 32'(err_count), 32'd0);
    chk("ign_meas", 32'(measured_tt), 32'h8);

    // Asynchronous abort mid-run.
    gate_tt   = 4'b1000;
    expect_tt = 4'b1000;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outs", 32'({gate_in, busy, done, pass, err_count,
                           fail_idx, measured_tt}), 32'd0);
    saw_done = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    chk("abort_nodone", 32'(saw_done), 32'd0);
    run(4'b1000, 4'b1000, n, seq);
    chk("abort_rerun_lat", 32'(n), 32'd12);
    chk("abort_rerun_pass", 32'(pass), 32'd1);

    // Three-input AND with single-cycle settle.
    for (int t = 0; t < 2; t++) begin
      gate_tt3 = 8'h80;
      expect3  = (t == 0) ? 8'h80 : 8'h88;
      @(negedge clk);
      start3 = 1'b1;
      @(posedge clk);
      #1;
      start3 = 1'b0;
      n = -1;
      for (int k = 1; k <= 60; k++) begin
        @(posedge clk);
        #1;
        if (done3) begin
          n = k;
          break;
        end
      end
      chk($sformatf("n3_%0d_latency", t), 32'(n), 32'd16);
      chk($sformatf("n3_%0d_meas", t), 32'(meas3), 32'h80);
      chk($sformatf("n3_%0d_pass", t), 32'(pass3), (t == 0) ? 32'd1 : 32'd0);
      chk($sformatf("n3_%0d_err", t), 32'(err3), (t == 0) ? 32'd0 : 32'd1);
      chk($sformatf("n3_%0d_fidx", t), 32'(fidx3), (t == 0) ? 32'd0 : 32'd3);
    end

    // Random gates and expected tables against the model.
    for (int r = 0; r < 24; r++) begin
      logic [3:0] g, e;
      g = 4'($urandom);
      e = ($urandom_range(0, 2) == 0) ? g : 4'($urandom);
      model(g, e, mp, mn, mfi);
      run(g, e, n, seq);
      chk($sformatf("rnd%0d_latency", r), 32'(n), 32'd12);
      chk($sformatf("rnd%0d_meas", r), 32'(measured_tt), 32'(g));
      chk($sformatf("rnd%0d_pass", r), 32'(pass), 32'(mp));
      chk($sformatf("rnd%0d_err", r), 32'(err_count), 32'(mn));
      chk($sformatf("rnd%0d_fidx", r), 32'(fail_idx), 32'(mfi));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
